// File: rtl/dom_pkg.sv
// Shared helpers for the pipelined DOM AND gadget.
// Holds the randomness index mapping for cross-domain share products,
// the randomness count per lane, flat-bus slice helpers and the default
// starvation-counter width. Imported by dom_and_lane and dom_and_pipe.
package dom_pkg;

    localparam int unsigned CntWDefault = 16;

    // Fresh random words needed per lane for d shares.
    function automatic int unsigned num_rnd(input int unsigned d);
        return d * (d - 1) / 2;
    endfunction

    // Random word shared by cross terms [i][j] and [j][i]; only meaningful for i != j.
    function automatic int unsigned rnd_idx(input int unsigned i, input int unsigned j);
        int unsigned lo;
        int unsigned hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo + hi * (hi - 1) / 2;
    endfunction

    // LSB of lane n, share s in a share-packed bus.
    function automatic int unsigned share_lsb(input int unsigned n, input int unsigned s,
                                              input int unsigned d, input int unsigned w);
        return (n * d + s) * w;
    endfunction

    // LSB of lane n, random word k in a randomness bus.
    function automatic int unsigned rnd_lsb(input int unsigned n, input int unsigned k,
                                            input int unsigned z, input int unsigned w);
        return (n * z + k) * w;
    endfunction

endpackage

// File: rtl/dom_and_lane.sv
// One lane of the DOM AND gadget.
// Computes all D*D share products, blinds each cross-domain pair with one
// shared random word, registers every term, then XOR-compresses per share.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears all terms)
//   load_i    - capture a new set of terms
//   flush_i   - zero the terms (ignored when load_i is high)
//   a_i, b_i  - D shares of W bits each, share s at [s*W +: W]
//   r_i       - num_rnd(D) random words, word k at [k*W +: W]
//   c_o       - D output shares, combinational from the term register only
module dom_and_lane
    import dom_pkg::*;
#(
    parameter int unsigned D = 2,
    parameter int unsigned W = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic                    flush_i,
    input  logic [D*W-1:0]          a_i,
    input  logic [D*W-1:0]          b_i,
    input  logic [num_rnd(D)*W-1:0] r_i,
    output logic [D*W-1:0]          c_o
);

    // Term [i][j] at [(i*D+j)*W +: W].
    logic [D*D*W-1:0] term_q;
    logic [D*D*W-1:0] term_d;

    always_comb begin
        term_d = term_q;
        if (load_i) begin
            for (int unsigned i = 0; i < D; i++) begin
                for (int unsigned j = 0; j < D; j++) begin
                    term_d[(i*D+j)*W +: W] = a_i[i*W +: W] & b_i[j*W +: W];
                    if (i != j) begin
                        term_d[(i*D+j)*W +: W] = term_d[(i*D+j)*W +: W]
                                                 ^ r_i[rnd_idx(i, j)*W +: W];
                    end
                end
            end
        end else if (flush_i) begin
            term_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            term_q <= '0;
        end else begin
            term_q <= term_d;
        end
    end

    always_comb begin
        c_o = '0;
        for (int unsigned i = 0; i < D; i++) begin
            for (int unsigned j = 0; j < D; j++) begin
                c_o[i*W +: W] = c_o[i*W +: W] ^ term_q[(i*D+j)*W +: W];
            end
        end
    end

endmodule

// File: rtl/dom_and_pipe.sv
// Handshaked, one-stage pipelined D-share DOM AND over N lanes of W bits.
// Operands and fresh randomness arrive on separate valid/ready channels and
// are consumed together only when both are valid and the output stage is free.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   in_valid_i / in_ready_o   - operand channel (a_i, b_i)
//   rnd_valid_i / rnd_ready_o - randomness channel (rnd_i)
//   out_valid_o / out_ready_i - result channel (c_o)
//   starve_cnt_o              - saturating count of cycles starved of randomness
// Optional build macro DOM_AND_PIPE_FLUSH_EN: zero the term registers when the
// result drains without a new load, so an idle stage holds no share data.
module dom_and_pipe
    import dom_pkg::*;
#(
    parameter int unsigned D     = 2,
    parameter int unsigned W     = 1,
    parameter int unsigned N     = 5,
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [N*D*W-1:0]          a_i,
    input  logic [N*D*W-1:0]          b_i,
    input  logic                      rnd_valid_i,
    output logic                      rnd_ready_o,
    input  logic [N*num_rnd(D)*W-1:0] rnd_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [N*D*W-1:0]          c_o,
    output logic [CNT_W-1:0]          starve_cnt_o
);

    localparam int unsigned Z = num_rnd(D);

    logic             stage_free;
    logic             fire;
    logic             flush;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    // Each ready depends only on the other channel's valid, never its own.
    always_comb begin
        stage_free  = !out_valid_q || out_ready_i;
        fire        = in_valid_i && rnd_valid_i && stage_free;
        in_ready_o  = rnd_valid_i && stage_free;
        rnd_ready_o = in_valid_i && stage_free;
    end

`ifdef DOM_AND_PIPE_FLUSH_EN
    assign flush = out_valid_q && out_ready_i && !fire;
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        if (fire) begin
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (in_valid_i && !rnd_valid_i && stage_free && (starve_cnt_q != {CNT_W{1'b1}})) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign starve_cnt_o = starve_cnt_q;

    for (genvar n = 0; n < N; n++) begin : g_lane
        dom_and_lane #(
            .D (D),
            .W (W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load_i  (fire),
            .flush_i (flush),
            .a_i     (a_i[n*D*W +: D*W]),
            .b_i     (b_i[n*D*W +: D*W]),
            .r_i     (rnd_i[n*Z*W +: Z*W]),
            .c_o     (c_o[n*D*W +: D*W])
        );
    end

endmodule
